// File: rtl/xpb_lut_bank.sv
// Runtime-loadable bank of NUM_LUTS precomputed-multiple tables, looked up in parallel.
// Optional macro XPB_LUT_SUM_EN adds out_sum (channel sum) and one extra output stage.
module xpb_lut_bank #(
  parameter int NUM_LUTS = 4,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 1024,
  localparam int LUT_W   = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [LUT_W-1:0]           load_lut,
  input  logic [IDX_W-1:0]           load_idx,
  input  logic [DATA_W-1:0]          load_data,
  input  logic                       load_done,
  output logic                       table_ready,
  output logic                       load_err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_LUTS*IDX_W-1:0]  in_idx,
  output logic                       out_valid,
`ifdef XPB_LUT_SUM_EN
  output logic [DATA_W+LUT_W-1:0]    out_sum,
`endif
  output logic [NUM_LUTS*DATA_W-1:0] out_data
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  // Handshake: a lookup beat transfers on a clock edge where in_valid && in_ready;
  // in_ready depends on state only, and out_valid is a one-cycle pulse with no backpressure.
  logic accept;
  logic lut_oob;
  logic wr_en;
  logic err_set;

  logic                      v_q;
  logic [NUM_LUTS*IDX_W-1:0] idx_q;
  logic [NUM_LUTS*DATA_W-1:0] rd_data;

  // State machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY:   if (load_start) state_d = ST_LOADING;
      ST_LOADING: begin
        if (load_start)     state_d = ST_LOADING;
        else if (load_done) state_d = ST_READY;
      end
      ST_READY:   if (load_start) state_d = ST_LOADING;
      default:    state_d = ST_EMPTY;
    endcase
  end

  assign table_ready = (state_q == ST_READY);
  assign in_ready    = (state_q == ST_READY);
  assign accept      = in_valid && in_ready;

  // Out-of-range table selects only exist when NUM_LUTS is not a power of two.
  if ((1 << LUT_W) > NUM_LUTS) begin : g_oob
    assign lut_oob = (int'(load_lut) >= NUM_LUTS);
  end else begin : g_no_oob
    assign lut_oob = 1'b0;
  end

  // Entry 0 is hard-wired to zero, so writes to it are simply discarded.
  assign wr_en = load_valid && (state_q == ST_LOADING) && !lut_oob && (load_idx != '0);

  assign err_set = (load_valid && ((state_q != ST_LOADING) || lut_oob)) ||
                   (in_valid && !in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       load_err <= 1'b0;
    else if (err_set) load_err <= 1'b1;
  end

  // Table storage, one array per channel, intentionally not reset.
  for (genvar g = 0; g < NUM_LUTS; g++) begin : g_lut
    logic [DATA_W-1:0] tbl [DEPTH];
    logic [IDX_W-1:0]  rd_idx;

    always_ff @(posedge clk) begin
      if (wr_en && (load_lut == LUT_W'(g))) tbl[load_idx] <= load_data;
    end

    assign rd_idx = idx_q[g*IDX_W +: IDX_W];
    assign rd_data[g*DATA_W +: DATA_W] = (rd_idx == '0) ? '0 : tbl[rd_idx];
  end

  // Stage 0: capture the accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= 1'b0;
      idx_q <= '0;
    end else begin
      v_q <= accept;
      if (accept) idx_q <= in_idx;
    end
  end

`ifdef XPB_LUT_SUM_EN
  localparam int SUM_W = DATA_W + LUT_W;

  logic                       v1_q;
  logic [NUM_LUTS*DATA_W-1:0] data1_q;
  logic [SUM_W-1:0]           sum_c;

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NUM_LUTS; k++) begin
      sum_c = sum_c + SUM_W'(data1_q[k*DATA_W +: DATA_W]);
    end
  end

  // Stage 1 registers the table read; stage 2 registers data and sum together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      data1_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sum   <= '0;
    end else begin
      v1_q      <= v_q;
      out_valid <= v1_q;
      if (v_q) data1_q <= rd_data;
      if (v1_q) begin
        out_data <= data1_q;
        out_sum  <= sum_c;
      end
    end
  end
`else
  // Stage 1: register the table read; out_data holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= v_q;
      if (v_q) out_data <= rd_data;
    end
  end
`endif

endmodule

// File: tb/tb_xpb_lut_bank.sv
// Bench for xpb_lut_bank (NUM_LUTS=2, IDX_W=2, DATA_W=16); covers XPB_LUT_SUM_EN builds too.
module tb_xpb_lut_bank;

  localparam int NL    = 2;
  localparam int IW    = 2;
  localparam int DW    = 16;
  localparam int LW    = 1;
  localparam int SW    = DW + LW;
  localparam int EXP_W = SW + NL*DW;
`ifdef XPB_LUT_SUM_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int ST_EMPTY = 0, ST_LOADING = 1, ST_READY = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             load_start, load_valid, load_done;
  logic [LW-1:0]    load_lut;
  logic [IW-1:0]    load_idx;
  logic [DW-1:0]    load_data;
  logic             table_ready, load_err;
  logic             in_valid, in_ready, out_valid;
  logic [NL*IW-1:0] in_idx;
  logic [NL*DW-1:0] out_data;
`ifdef XPB_LUT_SUM_EN
  logic [SW-1:0]    out_sum;
`endif

  xpb_lut_bank #(.NUM_LUTS(NL), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_lut(load_lut),
    .load_idx(load_idx), .load_data(load_data), .load_done(load_done),
    .table_ready(table_ready), .load_err(load_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .out_valid(out_valid),
`ifdef XPB_LUT_SUM_EN
    .out_sum(out_sum),
`endif
    .out_data(out_data)
  );

  // Reference model and scoreboard
  logic [DW-1:0]    ref_tbl [NL][1<<IW];
  int               m_state = ST_EMPTY;
  bit               m_err   = 1'b0;
  logic [EXP_W-1:0] exp_q[$];
  int               exp_t_q[$];
  int               vectors = 0;
  int               miscompares = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input int lut, input int idx);
    return (idx == 0) ? '0 : ref_tbl[lut][idx];
  endfunction

  // Monitor: pops on every out_valid, checks data, sum, latency and hold behaviour.
  logic [EXP_W-1:0] mon_e;
  int               mon_t;
  logic [NL*DW-1:0] last_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_data = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out_valid: got data=%0h expected no result", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        check("out_data", 64'(out_data), 64'(mon_e[NL*DW-1:0]));
`ifdef XPB_LUT_SUM_EN
        check("out_sum", 64'(out_sum), 64'(mon_e[EXP_W-1:NL*DW]));
`endif
        check("latency", 64'(cyc - mon_t), 64'(LAT));
      end
      last_data = out_data;
    end else begin
      check("out_data_hold", 64'(out_data), 64'(last_data));
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status();
    check("table_ready", 64'(table_ready), 64'(m_state == ST_READY));
    check("in_ready", 64'(in_ready), 64'(m_state == ST_READY));
    check("load_err", 64'(load_err), 64'(m_err));
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_state = ST_LOADING;
    check_status();
  endtask

  task automatic pulse_done();
    load_done = 1'b1;
    check("table_ready_pre", 64'(table_ready), 64'(m_state == ST_READY));
    tick();
    load_done = 1'b0;
    if (m_state == ST_LOADING) m_state = ST_READY;
    check_status();
  endtask

  task automatic write_entry(input int lut, input int idx, input logic [DW-1:0] d);
    load_valid = 1'b1;
    load_lut   = LW'(lut);
    load_idx   = IW'(idx);
    load_data  = d;
    if (m_state == ST_LOADING) begin
      if (idx != 0) ref_tbl[lut][idx] = d;
    end else begin
      m_err = 1'b1;
    end
    tick();
    load_valid = 1'b0;
  endtask

  task automatic lookup(input logic [NL*IW-1:0] idx);
    logic [NL*DW-1:0] d;
    logic [SW-1:0]    s;
    logic [DW-1:0]    v;
    check("in_ready_at_issue", 64'(in_ready), 64'(m_state == ST_READY));
    in_valid = 1'b1;
    in_idx   = idx;
    if (m_state == ST_READY) begin
      d = '0;
      s = '0;
      for (int k = 0; k < NL; k++) begin
        v = ref_rd(k, int'(idx[k*IW +: IW]));
        d[k*DW +: DW] = v;
        s = s + SW'(v);
      end
      exp_q.push_back({s, d});
      exp_t_q.push_back(cyc);
    end else begin
      m_err = 1'b1;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic random_lookups(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) != 0) lookup(NL*IW'($urandom_range(0, (1 << (NL*IW)) - 1)));
      else tick();
    end
  endtask

  task automatic full_reload();
    pulse_start();
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < (1 << IW); i++)
        write_entry(l, i, DW'($urandom_range(0, 16'hFFFF)));
    pulse_done();
  endtask

  // Main sequence
  initial begin
    rst_n = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_done = 1'b0;
    load_lut = '0; load_idx = '0; load_data = '0;
    in_valid = 1'b0; in_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
`ifdef XPB_LUT_SUM_EN
    check("rst_out_sum", 64'(out_sum), 64'd0);
`endif
    check_status();
    rst_n = 1'b1;
    tick();

    // Lookup before any table is loaded: dropped and flagged.
    lookup({2'd1, 2'd1});
    check_status();
    repeat (4) tick();

    // Initial load, including a discarded write to entry 0.
    pulse_start();
    write_entry(0, 1, 16'h1111); write_entry(0, 2, 16'h2222); write_entry(0, 3, 16'h3333);
    write_entry(1, 1, 16'hA000); write_entry(1, 2, 16'hB000); write_entry(1, 3, 16'hC000);
    write_entry(0, 0, 16'hFFFF);
    check_status();
    pulse_done();

    lookup({2'd2, 2'd3});
    repeat (4) tick();
    lookup({2'd0, 2'd0});
    lookup({2'd3, 2'd3});
    drain();

    // Back-to-back beats on channel 0: 1, 2, 3, 0.
    lookup({IW'($urandom_range(0, 3)), 2'd1});
    lookup({IW'($urandom_range(0, 3)), 2'd2});
    lookup({IW'($urandom_range(0, 3)), 2'd3});
    lookup({IW'($urandom_range(0, 3)), 2'd0});
    drain();

    // Reload while a beat is in flight: the beat sees the old contents.
    lookup({2'd1, 2'd1});
    pulse_start();
    write_entry(0, 1, 16'h5555);
    check_status();
    pulse_done();
    lookup({2'd1, 2'd1});
    drain();

    random_lookups(40);
    drain();

    // Asynchronous reset with beats in flight.
    lookup(4'($urandom_range(0, 15)));
    lookup(4'($urandom_range(0, 15)));
    lookup(4'($urandom_range(0, 15)));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
`ifdef XPB_LUT_SUM_EN
    check("midrst_out_sum", 64'(out_sum), 64'd0);
`endif
    exp_q.delete();
    exp_t_q.delete();
    m_state = ST_EMPTY;
    m_err = 1'b0;
    check_status();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check_status();

    // Fresh random tables; error flag must stay clear through the entry-0 write.
    full_reload();
    random_lookups(30);
    drain();

    // Write outside LOADING is dropped and flagged.
    write_entry(0, 2, 16'hDEAD);
    check_status();
    lookup({2'd2, 2'd2});
    drain();

    // Reload with random traffic before and after.
    random_lookups(10);
    full_reload();
    random_lookups(30);
    drain();
    check_status();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL timeout: got cycle=%0d expected completion", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
